// File: rtl/alu_operand_stage.sv
// Operand selector: decode, bypass and load-use interlock,
// registered through a 2-entry skid buffer whose head drives the outputs.
module alu_operand_stage #(
   parameter int XLEN = 32,
   parameter int NUM_BYP = 2,
   localparam int SHAMT_W = $clog2(XLEN)
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    FLUSH,
   input  logic                    IN_VALID,
   output logic                    IN_READY,
   input  logic [31:0]             INSTR,
   input  logic [XLEN-1:0]         PC,
   input  logic [XLEN-1:0]         RS1_DATA,
   input  logic [XLEN-1:0]         RS2_DATA,
   input  logic [NUM_BYP-1:0]      BYP_VALID,
   input  logic [5*NUM_BYP-1:0]    BYP_RD,
   input  logic [XLEN*NUM_BYP-1:0] BYP_DATA,
   input  logic                    LOAD_PEND,
   input  logic [4:0]              LOAD_RD,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
   output logic [XLEN-1:0]         DATA0,
   output logic [XLEN-1:0]         DATA1,
   output logic [3:0]              ALU_OP,
   output logic [4:0]              RD,
   output logic                    RD_WE,
   output logic                    ILLEGAL
);

   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;

   typedef struct packed {
      logic [XLEN-1:0] data0;
      logic [XLEN-1:0] data1;
      logic [3:0]      alu_op;
      logic [4:0]      rd;
      logic            rd_we;
      logic            illegal;
   } pay_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd_idx;
   logic [4:0] rs1_idx;
   logic [4:0] rs2_idx;
   logic       alt;

   assign opcode  = INSTR[6:0];
   assign rd_idx  = INSTR[11:7];
   assign funct3  = INSTR[14:12];
   assign rs1_idx = INSTR[19:15];
   assign rs2_idx = INSTR[24:20];
   assign alt     = INSTR[30];

   logic is_opimm;
   logic is_op;
   logic is_load;
   logic is_store;
   logic is_lui;
   logic is_auipc;
   logic is_jump;

   assign is_opimm = (opcode == OPC_OPIMM);
   assign is_op    = (opcode == OPC_OP);
   assign is_load  = (opcode == OPC_LOAD);
   assign is_store = (opcode == OPC_STORE);
   assign is_lui   = (opcode == OPC_LUI);
   assign is_auipc = (opcode == OPC_AUIPC);
   assign is_jump  = (opcode == OPC_JAL) || (opcode == OPC_JALR);

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] sh_imm;

   assign imm_i  = XLEN'($signed(INSTR[31:20]));
   assign imm_s  = XLEN'($signed({INSTR[31:25], INSTR[11:7]}));
   assign imm_u  = XLEN'($signed({INSTR[31:12], 12'b0}));
   assign sh_imm = XLEN'(INSTR[20 +: SHAMT_W]);

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   // Walk from the oldest source down so the lowest index is written last.
   always_comb begin
      rs1_val = RS1_DATA;
      rs2_val = RS2_DATA;
      for (int i = NUM_BYP - 1; i >= 0; i--) begin
         if (BYP_VALID[i] && (BYP_RD[5*i +: 5] == rs1_idx))
            rs1_val = BYP_DATA[XLEN*i +: XLEN];
         if (BYP_VALID[i] && (BYP_RD[5*i +: 5] == rs2_idx))
            rs2_val = BYP_DATA[XLEN*i +: XLEN];
      end
      if (rs1_idx == 5'd0) rs1_val = '0;
      if (rs2_idx == 5'd0) rs2_val = '0;
   end

   logic [3:0] f3_op;
   logic       is_shift;

   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      f3_op = OP_ADD;
      case (funct3)
         3'b000:  f3_op = (is_op && alt) ? OP_SUB : OP_ADD;
         3'b001:  f3_op = OP_SLL;
         3'b010:  f3_op = OP_SLT;
         3'b011:  f3_op = OP_SLTU;
         3'b100:  f3_op = OP_XOR;
         3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
         3'b110:  f3_op = OP_OR;
         default: f3_op = OP_AND;
      endcase
   end

   pay_t nxt;
   logic use1;
   logic use2;
   logic writes;

   always_comb begin
      nxt         = '0;
      nxt.rd      = rd_idx;
      nxt.alu_op  = OP_ADD;
      use1        = 1'b0;
      use2        = 1'b0;
      writes      = 1'b0;
      unique case (1'b1)
         is_opimm: begin
            use1       = 1'b1;
            writes     = 1'b1;
            nxt.alu_op = f3_op;
            nxt.data0  = rs1_val;
            nxt.data1  = is_shift ? sh_imm : imm_i;
         end
         is_op: begin
            use1       = 1'b1;
            use2       = 1'b1;
            writes     = 1'b1;
            nxt.alu_op = f3_op;
            nxt.data0  = rs1_val;
            nxt.data1  = is_shift ? XLEN'(rs2_val[SHAMT_W-1:0])
                                  : rs2_val;
         end
         is_load: begin
            use1      = 1'b1;
            writes    = 1'b1;
            nxt.data0 = rs1_val;
            nxt.data1 = imm_i;
         end
         is_store: begin
            use1      = 1'b1;
            nxt.data0 = rs1_val;
            nxt.data1 = imm_s;
         end
         is_lui: begin
            writes    = 1'b1;
            nxt.data1 = imm_u;
         end
         is_auipc: begin
            writes    = 1'b1;
            nxt.data0 = PC;
            nxt.data1 = imm_u;
         end
         is_jump: begin
            writes    = 1'b1;
            nxt.data0 = PC;
            nxt.data1 = XLEN'(4);
         end
         default: nxt.illegal = 1'b1;
      endcase
      nxt.rd_we = writes && (rd_idx != 5'd0);
   end

   logic interlock;

   assign interlock = LOAD_PEND && (LOAD_RD != 5'd0) &&
                      ((use1 && (rs1_idx == LOAD_RD)) ||
                       (use2 && (rs2_idx == LOAD_RD)));

   pay_t head;
   pay_t tail;
   logic v0;
   logic v1;
   logic accept;
   logic drain;

   assign IN_READY = !interlock && !v1;
   assign accept   = IN_VALID && IN_READY;
   assign drain    = v0 && OUT_READY;

   // v1 implies v0; the head register is what the ALU sees.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         v0   <= 1'b0;
         v1   <= 1'b0;
         head <= '0;
         tail <= '0;
      end else if (FLUSH) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else if (!v0) begin
         if (accept) begin
            head <= nxt;
            v0   <= 1'b1;
         end
      end else if (!v1) begin
         if (drain) begin
            if (accept) head <= nxt;
            else        v0   <= 1'b0;
         end else if (accept) begin
            tail <= nxt;
            v1   <= 1'b1;
         end
      end else if (drain) begin
         head <= tail;
         v1   <= 1'b0;
      end
   end

   assign OUT_VALID = v0;
   assign DATA0     = head.data0;
   assign DATA1     = head.data1;
   assign ALU_OP    = head.alu_op;
   assign RD        = head.rd;
   assign RD_WE     = head.rd_we;
   assign ILLEGAL   = head.illegal;

endmodule
